// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one shift-add multiplier between two requesters.
// Optional early termination when the multiplier runs out of set bits: MULT_RR_SCHED_EARLY_TERM_EN.
module mult_rr_sched #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_p,
  output logic               res_id,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_add;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               last_grant;
  logic               grant;
  logic               accept;
  logic               run_last;

  // With both requesting, the one not served last time wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = rst && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst && (state == IDLE) && req1_valid && grant;
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  assign acc_add = acc + (mplier[0] ? mcand : '0);

`ifdef MULT_RR_SCHED_EARLY_TERM_EN
  assign run_last = (count == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign run_last = (count == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (run_last)  state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      res_p      <= '0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand      <= {{WIDTH{1'b0}}, (grant ? req1_a : req0_a)};
          mplier     <= grant ? req1_b : req0_b;
          acc        <= '0;
          count      <= '0;
          last_grant <= grant;
          res_id     <= grant;
        end
        RUN: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (run_last) res_p <= acc_add;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_rr_sched.md
Name: mult_rr_sched

Overview:
- Two-requester scheduler that shares one iterative unsigned shift-add multiplier core.
- Arbitrates round-robin between two operand sources and sequences the multiplication one multiplier bit per clock.
- Returns the product with the winning requester's ID on a valid/ready result channel.
- Sits between operand producers and the shift-add multiplier datapath; the datapath is instantiated internally.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_a  input  WIDTH  requester 0 multiplicand.
- req0_b  input  WIDTH  requester 0 multiplier.
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- req1_a  input  WIDTH  requester 1 multiplicand.
- req1_b  input  WIDTH  requester 1 multiplier.
- res_valid  output  1  product available.
- res_ready  input  1  consumer takes product.
- res_p  output  2*WIDTH  unsigned product.
- res_id  output  1  requester that owns res_p.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset: clock and reset are clk and rst. rst is asynchronous and active-low.
  - While rst=0: state=IDLE, res_valid=0, res_p=0, res_id=0, busy=0, req*_ready=0, count=0, accumulator=0, last_grant=1.
  - last_grant=1 means requester 0 wins first.
- States: IDLE, RUN, DONE.
- IDLE:
  - req*_ready is driven combinationally, and only in IDLE.
  - Only one requester is granted.
  - If one valid, grant it. If both valid, grant the one != last_grant.
  - A handshake is req_valid & req_ready at a rising edge.
  - On the handshake edge (E0): capture a into the multiplicand reg (zero-extended to 2*WIDTH) and b into the multiplier reg.
  - Also on E0: clear accumulator, count=0, last_grant=grant, res_id=grant, state→RUN.
- RUN, each edge:
  - If multiplier[0]=1, accumulator += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, count++.
  - When count==WIDTH-1 on that edge, state→DONE and res_p=final accumulator.
- Latency: res_valid rises exactly WIDTH edges after E0 (edge E0+WIDTH). req*_ready stays low throughout.
- DONE:
  - res_valid=1; res_p and res_id held stable until res_valid & res_ready.
  - On that edge: state→IDLE, res_valid=0. res_p holds its last value.
  - No operand acceptance on the same edge; the next grant is at the earliest one cycle later.
  - Minimum throughput: one product per WIDTH+2 cycles.
- Arithmetic: unsigned; the 2*WIDTH accumulator cannot overflow. Operand 0 gives product 0 with full latency.
- Requester-side rules: requesters may drop valid while not granted; no fairness credit is kept. The scheduler ignores a*/b* changes after E0.
- Reset mid-operation: the in-flight product is discarded with no result emitted. After release, the first grant goes to requester 0.
- res_ready high while res_valid=0 has no effect.

Optional Feature:
- Macro: MULT_RR_SCHED_EARLY_TERM_EN.
- Defined: in RUN, if the post-shift multiplier register is zero, go to DONE on that edge. Latency = max(1, index of highest set bit of b + 1) edges after E0. b=0 takes 1 edge.
- Undefined: fixed WIDTH-edge latency as above. Result values are identical in both builds.

Test Plan:
- Single request: req0 a=8, b=8, res_ready=1 → req0_ready high in IDLE. res_valid 8 edges after accept, res_p=64, res_id=0, busy high during RUN/DONE.
- Simultaneous requests:
  - Step 1: after reset, req0 (3,5) and req1 (255,255) both valid → req0 granted first, res_p=15, res_id=0.
  - Step 2: req1 granted next → res_p=65025, res_id=1.
- Round-robin: both requesters held valid for 4 transactions → res_id sequence 0,1,0,1. req1 held valid alone for 2 transactions → 1,1.
- Backpressure: a=200, b=100, res_ready=0 for 5 cycles after res_valid → res_p=20000 and res_id stable, both req*_ready=0. Release → IDLE one edge later.
- Reset mid-RUN: assert rst=0 at count=3 → all outputs zero immediately (asynchronous). After release, no res_valid until a new request. New request a=0, b=77 → res_p=0 after 8 edges.
- Early-term build: a=9, b=1 → res_valid 1 edge after accept, res_p=9. Without macro: 8 edges, res_p=9.
